match_merge_readout: RTL and testbench

Eight-way readout merger for the match calculator front end. On each new event it reads up to 63 entries from each of eight one-cycle-latency input memories (match-engine pair lists). It emits one merged stream of `{proj_index, stub_index}` words, one word per clock. The stream is grouped so that entries with the same projection key arrive together, which the downstream residual/best-match logic requires.

---
 rtl/match_merge_pkg.sv | 21 ++
 rtl/match_merge_readout_if.sv | 12 +
 rtl/match_merge_readout_min_key_select.sv | 23 ++
 rtl/match_merge_readout.sv | 65 ++++++
 tb/tb_match_merge_readout.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/match_merge_pkg.sv
// match_merge_pkg: shared widths, types and the pairwise min-key pick for the readout merger.
package match_merge_pkg;
  localparam int N_IN = 8;
  localparam int DATA_WIDTH = 12;
  localparam int ADDR_WIDTH = 6;
  localparam int KEY_MSB = 11;
  localparam int KEY_WIDTH = KEY_MSB - ADDR_WIDTH + 1;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [KEY_WIDTH-1:0] key_t;
  typedef logic [$clog2(N_IN)-1:0] idx_t;
  typedef struct packed {
    logic v;
    key_t key;
    idx_t idx;
  } cand_t;
  // a is always the lower-index side, so <= keeps ties on the lowest input
  function automatic cand_t pick(cand_t a, cand_t b);
    return (a.v && (!b.v || a.key <= b.key)) ? a : b;
  endfunction
endpackage

// File: rtl/match_merge_readout_if.sv
// match_merge_readout_if: event control, memory read ports and merged output stream.
interface match_merge_readout_if;
  import match_merge_pkg::*;
  logic new_event;
  addr_t number_in [N_IN];
  addr_t addr_out [N_IN];
  data_t data_in [N_IN];
  data_t data_out;
  logic valid_out;
  modport master (output new_event, number_in, data_in, input addr_out, data_out, valid_out);
  modport slave (input new_event, number_in, data_in, output addr_out, data_out, valid_out);
endinterface

// File: rtl/match_merge_readout_min_key_select.sv
// min_key_select: 8-input comparator tree returning a one-hot winner with the smallest key, ties to lowest index.
module min_key_select
  import match_merge_pkg::*;
(
  input  logic [N_IN-1:0] valid_i,
  input  key_t            key_i [N_IN],
  output logic [N_IN-1:0] sel_o,
  output logic            any_o
);
  cand_t l0 [8];
  cand_t l1 [4];
  cand_t l2 [2];
  cand_t win;
  always_comb begin
    for (int i = 0; i < 8; i++) l0[i] = '{v: valid_i[i], key: key_i[i], idx: idx_t'(i)};
    for (int i = 0; i < 4; i++) l1[i] = pick(l0[2*i], l0[2*i+1]);
    for (int i = 0; i < 2; i++) l2[i] = pick(l1[2*i], l1[2*i+1]);
    win = pick(l2[0], l2[1]);
    any_o = win.v;
    sel_o = '0;
    sel_o[win.idx] = win.v;
  end
endmodule

// File: rtl/match_merge_readout.sv
// match_merge_readout: eight-way readout merger, one word per clock from one-cycle-latency memories.
// MERGE_READOUT_SORT_EN selects the minimum-key merge; otherwise inputs drain in index order.
module match_merge_readout
  import match_merge_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  match_merge_readout_if.slave bus
);
  addr_t rd_ptr_q [N_IN];
  addr_t rd_ptr_d [N_IN];
  addr_t count_q [N_IN];
  logic primed_q;
  logic valid_q;
  data_t data_q;
  data_t head_sel;
  logic [N_IN-1:0] head_valid;
  logic [N_IN-1:0] sel;
  key_t key [N_IN];
  logic any_valid;
  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      head_valid[i] = primed_q && (rd_ptr_q[i] < count_q[i]);
`ifdef MERGE_READOUT_SORT_EN
      key[i] = bus.data_in[i][KEY_MSB:ADDR_WIDTH];
`else
      key[i] = '0;
`endif
    end
  end
  min_key_select u_sel (
    .valid_i (head_valid),
    .key_i   (key),
    .sel_o   (sel),
    .any_o   (any_valid)
  );
  // presenting the advanced pointer now makes next cycle's data_in the new head
  always_comb begin
    head_sel = '0;
    for (int i = 0; i < N_IN; i++) begin
      head_sel |= sel[i] ? bus.data_in[i] : '0;
      rd_ptr_d[i] = bus.new_event ? '0 : rd_ptr_q[i] + addr_t'(sel[i]);
      bus.addr_out[i] = rd_ptr_d[i];
    end
  end
  assign bus.data_out = data_q;
  assign bus.valid_out = valid_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '{default: '0};
      count_q <= '{default: '0};
      primed_q <= 1'b0;
      data_q <= '0;
      valid_q <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      if (bus.new_event) begin
        count_q <= bus.number_in;
        primed_q <= 1'b1;
      end
      data_q <= head_sel;
      valid_q <= any_valid;
    end
  end
endmodule

// File: tb/tb_match_merge_readout.sv
// tb_match_merge_readout: directed events with a scoreboard queue drained by an output monitor.
module tb_match_merge_readout;
  import match_merge_pkg::*;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  match_merge_readout_if bus ();
  match_merge_readout dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  data_t mem [N_IN][64];
  data_t exp_q [$];
  data_t exp_w;
  int cyc = 0;
  int n_pass = 0;
  int n_chk = 0;
  int n_v, first_v, last_v;
  int t, t2;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < N_IN; i++) bus.data_in[i] <= mem[i][bus.addr_out[i]];
  end
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask
  always @(negedge clk) begin
    if (bus.valid_out === 1'b1) begin
      if (n_v == 0) first_v = cyc;
      last_v = cyc;
      n_v++;
      if (exp_q.size() == 0) chk("unexpected word", int'(bus.data_out), -1);
      else begin
        exp_w = exp_q.pop_front();
        chk("word", int'(bus.data_out), int'(exp_w));
      end
    end
  end
  function automatic data_t mk(input int k, input int s);
    return data_t'((k << ADDR_WIDTH) | s);
  endfunction
  function automatic int addr_or();
    int r = 0;
    for (int i = 0; i < N_IN; i++) r |= int'(bus.addr_out[i]);
    return r;
  endfunction
  task automatic zero_numbers();
    for (int i = 0; i < N_IN; i++) bus.number_in[i] = '0;
  endtask
  task automatic raise(output int tt);
    @(posedge clk);
    #1;
    bus.new_event = 1'b1;
    tt = cyc;
  endtask
  task automatic lower();
    @(posedge clk);
    #1;
    bus.new_event = 1'b0;
  endtask
  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic win(input string nm, input int tt, input int n);
    chk({nm, " valid count"}, n_v, n);
    if (n > 0) begin
      chk({nm, " first valid"}, first_v, tt + 2);
      chk({nm, " last valid"}, last_v, tt + n + 1);
    end
    chk({nm, " drained"}, exp_q.size(), 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.new_event = 1'b0;
    zero_numbers();
    for (int i = 0; i < N_IN; i++) for (int k = 0; k < 64; k++) mem[i][k] = '0;
    n_v = 0;
    rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      bus.new_event = 1'($urandom_range(0, 1));
      for (int i = 0; i < N_IN; i++) bus.number_in[i] = addr_t'($urandom);
      @(negedge clk);
      chk("reset valid_out", int'(bus.valid_out), 0);
      chk("reset addr_out", addr_or(), 0);
    end
    @(posedge clk);
    #1;
    bus.new_event = 1'b0;
    zero_numbers();
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle no valid", n_v, 0);
    // single input, repeated key
    mem[2][0] = mk(5, 10);
    mem[2][1] = mk(5, 3);
    mem[2][2] = mk(7, 1);
    bus.number_in[2] = 6'd3;
    exp_q.push_back(mk(5, 10));
    exp_q.push_back(mk(5, 3));
    exp_q.push_back(mk(7, 1));
    n_v = 0;
    raise(t);
    @(negedge clk);
    chk("addr3 seq 0", int'(bus.addr_out[2]), 0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      bus.new_event = 1'b0;
      @(negedge clk);
      chk("addr3 seq", int'(bus.addr_out[2]), k);
    end
    wait_to(t + 8);
    win("single", t, 3);
    // three inputs with interleaved keys
    zero_numbers();
    mem[0][0] = mk(2, 11);
    mem[0][1] = mk(9, 12);
    mem[1][0] = mk(2, 21);
    mem[1][1] = mk(4, 22);
    mem[7][0] = mk(1, 31);
    bus.number_in[0] = 6'd2;
    bus.number_in[1] = 6'd2;
    bus.number_in[7] = 6'd1;
`ifdef MERGE_READOUT_SORT_EN
    exp_q.push_back(mk(1, 31));
    exp_q.push_back(mk(2, 11));
    exp_q.push_back(mk(2, 21));
    exp_q.push_back(mk(4, 22));
    exp_q.push_back(mk(9, 12));
`else
    exp_q.push_back(mk(2, 11));
    exp_q.push_back(mk(9, 12));
    exp_q.push_back(mk(2, 21));
    exp_q.push_back(mk(4, 22));
    exp_q.push_back(mk(1, 31));
`endif
    n_v = 0;
    raise(t);
    lower();
    wait_to(t + 10);
    win("merge", t, 5);
    // all inputs empty
    zero_numbers();
    n_v = 0;
    raise(t);
    lower();
    wait_to(t + 10);
    win("empty", t, 0);
    // abort a long stream with a second event
    for (int k = 0; k < 20; k++) mem[0][k] = mk(k, k + 1);
    bus.number_in[0] = 6'd20;
    for (int k = 0; k < 6; k++) exp_q.push_back(mk(k, k + 1));
    exp_q.push_back(mk(0, 1));
    exp_q.push_back(mk(1, 2));
    n_v = 0;
    raise(t);
    lower();
    wait_to(t + 5);
    bus.number_in[0] = 6'd2;
    raise(t2);
    chk("abort pulse cycle", t2, t + 6);
    lower();
    wait_to(t + 14);
    win("abort", t, 8);
    // full depth on all inputs
    for (int i = 0; i < N_IN; i++) begin
      for (int k = 0; k < 63; k++) mem[i][k] = mk(k, i);
      bus.number_in[i] = 6'd63;
    end
`ifdef MERGE_READOUT_SORT_EN
    for (int k = 0; k < 63; k++) for (int i = 0; i < N_IN; i++) exp_q.push_back(mk(k, i));
`else
    for (int i = 0; i < N_IN; i++) for (int k = 0; k < 63; k++) exp_q.push_back(mk(k, i));
`endif
    n_v = 0;
    raise(t);
    lower();
    wait_to(t + 512);
    win("full", t, 504);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
